// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add sequencer: word width, FSM
// encodings and the index-counter width helper.
package multiword_add_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter width; never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words <= 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/carry_lookahead_16bit.sv
// 16-bit adder built from four 4-bit groups with group-level carry lookahead.
module carry_lookahead_16bit (
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [15:0] g;
    logic [15:0] p;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  cg;
    logic        cc;

    always_comb begin
        g  = X & Y;
        p  = X ^ Y;
        gg = '0;
        gp = '0;
        cg = '0;
        cc = 1'b0;
        S  = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
        // Group carries come straight from group generate/propagate terms.
        cg[0] = Cin;
        cg[1] = gg[0] | (gp[0] & Cin);
        cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
        cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & Cin);
        Cout  = gg[3] | (gp[3] & cg[3]);
        for (int k = 0; k < 4; k++) begin
            cc = cg[k];
            for (int j = 0; j < 4; j++) begin
                S[4*k+j] = p[4*k+j] ^ cc;
                cc       = g[4*k+j] | (p[4*k+j] & cc);
            end
        end
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Adds two WORDS x 16-bit operands one word per cycle through one shared
// 16-bit adder. Define MULTIWORD_ADD_SUB_EN to add a Sub input (A - B).
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Start,
    input  logic [WORD_W*WORDS-1:0]   A,
    input  logic [WORD_W*WORDS-1:0]   B,
    input  logic                      Cin,
`ifdef MULTIWORD_ADD_SUB_EN
    input  logic                      Sub,
`endif
    output logic                      Ready,
    output logic                      Busy,
    output logic                      Done,
    output logic [WORD_W*WORDS-1:0]   Sum,
    output logic                      Cout,
    output logic                      Ovf,
    output state_t                    dbg_state
);

    // Handshake: a request is taken on any rising edge where Start=1 and
    // Ready=1; Start at any other time is dropped. Done pulses for one cycle
    // and Sum/Cout/Ovf stay valid until the next accepted request.

    localparam int N     = WORD_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);

    state_t             state_q;
    state_t             state_n;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [N-1:0]       a_lat;
    logic [N-1:0]       b_lat;
    logic               last_word;
    logic [WORD_W-1:0]  x_word;
    logic [WORD_W-1:0]  y_word;
    logic [WORD_W-1:0]  add_s;
    logic               add_cout;

`ifdef MULTIWORD_ADD_SUB_EN
    logic               sub_lat;
    assign y_word = sub_lat ? ~b_lat[WORD_W*idx_q +: WORD_W] : b_lat[WORD_W*idx_q +: WORD_W];
`else
    assign y_word = b_lat[WORD_W*idx_q +: WORD_W];
`endif

    assign x_word    = a_lat[WORD_W*idx_q +: WORD_W];
    assign last_word = (idx_q == IDX_W'(WORDS - 1));
    assign dbg_state = state_q;

    carry_lookahead_16bit u_adder (
        .X    (x_word),
        .Y    (y_word),
        .Cin  (carry_q),
        .S    (add_s),
        .Cout (add_cout)
    );

    always_comb begin
        state_n = state_q;
        Ready   = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        case (state_q)
            IDLE: begin
                Ready = 1'b1;
                if (Start) state_n = ADD;
            end
            ADD: begin
                Busy = 1'b1;
                if (last_word) state_n = DONE;
            end
            DONE: begin
                Busy    = 1'b1;
                Done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_lat   <= '0;
            b_lat   <= '0;
            Sum     <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
            sub_lat <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            case (state_q)
                IDLE: if (Start) begin
                    a_lat <= A;
                    b_lat <= B;
                    idx_q <= '0;
`ifdef MULTIWORD_ADD_SUB_EN
                    sub_lat <= Sub;
                    carry_q <= Sub ? 1'b1 : Cin;
`else
                    carry_q <= Cin;
`endif
                end
                ADD: begin
                    Sum[WORD_W*idx_q +: WORD_W] <= add_s;
                    carry_q <= add_cout;
                    if (last_word) begin
                        // y_word carries the (possibly inverted) B sign bit here.
                        Cout  <= add_cout;
                        Ovf   <= (a_lat[N-1] == y_word[WORD_W-1]) && (add_s[WORD_W-1] != a_lat[N-1]);
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
